hazard_unit: RTL and testbench

Pipeline hazard control for the five-stage MIPS core, sitting in the ID stage directly upstream of the EX-stage forwarding unit. Forwarding resolves most RAW hazards. This block handles the ones it cannot:
- load-use dependencies, resolved by stalling IF/ID and inserting an ID/EX bubble;
- taken branches resolved in EX, resolved by flushing IF/ID and ID/EX;
- HI/LO or mult/div structural hazards while the iterative multiply/divide unit is busy, tracked by an internal busy FSM.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 124 ++++++++++++
 tb/tb_hazard_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard control for the five-stage MIPS pipeline.
// Detects load-use and mult/div HI/LO hazards, applies branch-flush priority,
// tracks mult/div occupancy with a busy FSM and counts stalled cycles.
module hazard_unit #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_if_id,
    input  logic [4:0]  rt_if_id,
    input  logic        rs_src_IF_ID,
    input  logic        rt_src_IF_ID,
    input  logic        muldiv_if_id,
    input  logic        hilo_use_if_id,
    input  logic        mem_rd_id_ex,
    input  logic        wr_reg_id_ex,
    input  logic [4:0]  reg2wr_id_ex,
    input  logic        muldiv_start_ex,
    input  logic        branch_taken_ex,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               done_next;
    logic               load_use;
    logic               md_hazard;
    logic               stall;

    assign muldiv_busy = (state == BUSY);

    // Hazard detection: load-use on rs/rt (never for $0) and HI/LO use while mult/div busy
    always_comb begin
        load_use  = mem_rd_id_ex && wr_reg_id_ex && (reg2wr_id_ex != 5'd0) &&
                    ((rs_src_IF_ID && (rs_if_id == reg2wr_id_ex)) ||
                     (rt_src_IF_ID && (rt_if_id == reg2wr_id_ex)));
        md_hazard = muldiv_busy && (hilo_use_if_id || muldiv_if_id);
        stall     = load_use || md_hazard;
    end

    // Pipeline control: reset hold, then branch redirect over stall over normal flow
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Mult/div busy FSM next state: start while busy is ignored, branches do not cancel
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (muldiv_start_ex) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Mult/div FSM state, down-counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            muldiv_done <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            muldiv_done <= done_next;
        end
    end

    // Saturating stall-cycle counter; squashed (branch) cycles are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !branch_taken_ex && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit.
module tb_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_if_id;
    logic [4:0]  rt_if_id;
    logic        rs_src_IF_ID;
    logic        rt_src_IF_ID;
    logic        muldiv_if_id;
    logic        hilo_use_if_id;
    logic        mem_rd_id_ex;
    logic        wr_reg_id_ex;
    logic [4:0]  reg2wr_id_ex;
    logic        muldiv_start_ex;
    logic        branch_taken_ex;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [15:0] stall_cnt;

    logic        pc_write1;
    logic        if_id_write1;
    logic        if_id_flush1;
    logic        id_ex_bubble1;
    logic        muldiv_busy1;
    logic        muldiv_done1;
    logic [15:0] stall_cnt1;

    int tests;
    int fails;

    wire [3:0] ctrl = {pc_write, if_id_write, if_id_flush, id_ex_bubble};

    hazard_unit #(.MULDIV_LAT(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .rs_src_IF_ID(rs_src_IF_ID), .rt_src_IF_ID(rt_src_IF_ID),
        .muldiv_if_id(muldiv_if_id), .hilo_use_if_id(hilo_use_if_id),
        .mem_rd_id_ex(mem_rd_id_ex), .wr_reg_id_ex(wr_reg_id_ex),
        .reg2wr_id_ex(reg2wr_id_ex), .muldiv_start_ex(muldiv_start_ex),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .stall_cnt(stall_cnt)
    );

    hazard_unit #(.MULDIV_LAT(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .rs_src_IF_ID(rs_src_IF_ID), .rt_src_IF_ID(rt_src_IF_ID),
        .muldiv_if_id(muldiv_if_id), .hilo_use_if_id(hilo_use_if_id),
        .mem_rd_id_ex(mem_rd_id_ex), .wr_reg_id_ex(wr_reg_id_ex),
        .reg2wr_id_ex(reg2wr_id_ex), .muldiv_start_ex(muldiv_start_ex),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write1), .if_id_write(if_id_write1),
        .if_id_flush(if_id_flush1), .id_ex_bubble(id_ex_bubble1),
        .muldiv_busy(muldiv_busy1), .muldiv_done(muldiv_done1),
        .stall_cnt(stall_cnt1)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_if_id = '0; rt_if_id = '0; rs_src_IF_ID = 0; rt_src_IF_ID = 0;
        muldiv_if_id = 0; hilo_use_if_id = 0; mem_rd_id_ex = 0; wr_reg_id_ex = 0;
        reg2wr_id_ex = '0; muldiv_start_ex = 0; branch_taken_ex = 0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        mem_rd_id_ex = 1; wr_reg_id_ex = 1; reg2wr_id_ex = r;
        rs_if_id = r; rs_src_IF_ID = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #1;
        tests++;
        if (ctrl !== 4'b0001) begin fails++; $display("FAIL reset_ctrl got %b want 0001", ctrl); end
        tests++;
        if ({muldiv_busy, muldiv_done} !== 2'b00) begin fails++; $display("FAIL reset_md got %b want 00", {muldiv_busy, muldiv_done}); end
        set_load_use(5'd3);
        step();
        tests++;
        if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        clear_inputs();
        rst_n = 1;
        #1;
        tests++;
        if (ctrl !== 4'b1100) begin fails++; $display("FAIL post_reset_ctrl got %b want 1100", ctrl); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        #1;
        tests++;
        if (ctrl !== 4'b0001) begin fails++; $display("FAIL lu_stall got %b want 0001", ctrl); end
        step();
        // bubble moved the load to MEM
        mem_rd_id_ex = 0; wr_reg_id_ex = 0;
        #1;
        tests++;
        if (ctrl !== 4'b1100) begin fails++; $display("FAIL lu_release got %b want 1100", ctrl); end
        tests++;
        if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        // load-use via rt
        clear_inputs();
        mem_rd_id_ex = 1; wr_reg_id_ex = 1; reg2wr_id_ex = 5'd9; rt_if_id = 5'd9; rt_src_IF_ID = 1;
        #1;
        tests++;
        if (ctrl !== 4'b0001) begin fails++; $display("FAIL lu_rt got %b want 0001", ctrl); end
        clear_inputs();
    endtask

    task automatic test_no_stall();
        do_reset();
        set_load_use(5'd0);
        #1;
        tests++;
        if (ctrl !== 4'b1100) begin fails++; $display("FAIL ns_r0 got %b want 1100", ctrl); end
        set_load_use(5'd5); rs_src_IF_ID = 0;
        #1;
        tests++;
        if (ctrl !== 4'b1100) begin fails++; $display("FAIL ns_nosrc got %b want 1100", ctrl); end
        set_load_use(5'd5); mem_rd_id_ex = 0;
        #1;
        tests++;
        if (ctrl !== 4'b1100) begin fails++; $display("FAIL ns_noload got %b want 1100", ctrl); end
        set_load_use(5'd5); rs_if_id = 5'd6;
        #1;
        tests++;
        if (ctrl !== 4'b1100) begin fails++; $display("FAIL ns_mismatch got %b want 1100", ctrl); end
        hilo_use_if_id = 1; muldiv_if_id = 1;
        step();
        tests++;
        if ({ctrl, stall_cnt} !== {4'b1100, 16'd0}) begin fails++; $display("FAIL ns_idle_hilo got %b/%0d want 1100/0", ctrl, stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch_over_stall();
        do_reset();
        set_load_use(5'd4);
        step();
        // stall_cnt now 1; redirect squashes the stalled instruction
        branch_taken_ex = 1;
        #1;
        tests++;
        if (ctrl !== 4'b1111) begin fails++; $display("FAIL br_ctrl got %b want 1111", ctrl); end
        step();
        tests++;
        if (stall_cnt !== 16'd1) begin fails++; $display("FAIL br_cnt got %0d want 1", stall_cnt); end
        clear_inputs();
    endtask

    // mflo held in ID behind a 32-cycle mult; optional branch at iteration br_iter
    task automatic test_muldiv(input int br_iter, input logic [15:0] exp_cnt);
        do_reset();
        muldiv_start_ex = 1;
        #1;
        tests++;
        if ({muldiv_busy, ctrl} !== {1'b0, 4'b1100}) begin fails++; $display("FAIL md_issue got %b want 01100", {muldiv_busy, ctrl}); end
        step();
        muldiv_start_ex = 0;
        hilo_use_if_id = 1;
        for (int i = 0; i < 32; i++) begin
            branch_taken_ex = (i == br_iter);
            if (i == 5) set_load_use(5'd7);
            else begin mem_rd_id_ex = 0; wr_reg_id_ex = 0; rs_src_IF_ID = 0; end
            if (i == 20) muldiv_start_ex = 1;
            else muldiv_start_ex = 0;
            #1;
            tests++;
            if ({muldiv_busy, muldiv_done} !== 2'b10) begin fails++; $display("FAIL md_busy[%0d] got %b want 10", i, {muldiv_busy, muldiv_done}); end
            tests++;
            if (ctrl !== ((i == br_iter) ? 4'b1111 : 4'b0001)) begin fails++; $display("FAIL md_ctrl[%0d] got %b", i, ctrl); end
            step();
        end
        clear_inputs();
        hilo_use_if_id = 1;
        #1;
        tests++;
        if ({muldiv_busy, muldiv_done, ctrl} !== 6'b011100) begin fails++; $display("FAIL md_done got %b want 011100", {muldiv_busy, muldiv_done, ctrl}); end
        tests++;
        if (stall_cnt !== exp_cnt) begin fails++; $display("FAIL md_cnt got %0d want %0d", stall_cnt, exp_cnt); end
        step();
        tests++;
        if ({muldiv_busy, muldiv_done} !== 2'b00) begin fails++; $display("FAIL md_after got %b want 00", {muldiv_busy, muldiv_done}); end
        clear_inputs();
    endtask

    task automatic test_lat1();
        do_reset();
        muldiv_start_ex = 1;
        step();
        muldiv_start_ex = 0;
        tests++;
        if ({muldiv_busy1, muldiv_done1} !== 2'b10) begin fails++; $display("FAIL lat1_busy got %b want 10", {muldiv_busy1, muldiv_done1}); end
        step();
        tests++;
        if ({muldiv_busy1, muldiv_done1} !== 2'b01) begin fails++; $display("FAIL lat1_done got %b want 01", {muldiv_busy1, muldiv_done1}); end
        step();
        tests++;
        if ({muldiv_busy1, muldiv_done1} !== 2'b00) begin fails++; $display("FAIL lat1_after got %b want 00", {muldiv_busy1, muldiv_done1}); end
    endtask

    task automatic test_reset_mid_busy();
        int done_seen;
        do_reset();
        muldiv_start_ex = 1;
        step();
        muldiv_start_ex = 0;
        hilo_use_if_id = 1;
        repeat (10) step();
        tests++;
        if ({muldiv_busy, stall_cnt} !== {1'b1, 16'd10}) begin fails++; $display("FAIL rmb_pre got %b/%0d want 1/10", muldiv_busy, stall_cnt); end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if ({muldiv_busy, ctrl, stall_cnt} !== {1'b0, 4'b0001, 16'd0}) begin fails++; $display("FAIL rmb_reset got %b/%b/%0d want 0/0001/0", muldiv_busy, ctrl, stall_cnt); end
        step();
        step();
        rst_n = 1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (muldiv_done || muldiv_busy) done_seen++;
            step();
        end
        tests++;
        if (done_seen !== 0) begin fails++; $display("FAIL rmb_nodone got %0d busy/done cycles want 0", done_seen); end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use(5'd12);
        repeat (65534) @(posedge clk);
        #1;
        tests++;
        if (stall_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_pre got %h want fffe", stall_cnt); end
        repeat (4466) @(posedge clk);
        #1;
        tests++;
        if ({ctrl, stall_cnt} !== {4'b0001, 16'hFFFF}) begin fails++; $display("FAIL sat_hold got %b/%h want 0001/ffff", ctrl, stall_cnt); end
        clear_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_over_stall();
        test_muldiv(-1, 16'd32);
        test_muldiv(10, 16'd31);
        test_lat1();
        test_reset_mid_busy();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
